// File: rtl/excp_ctrl.sv
// Exception/ertn sequencer: picks one event by fixed priority, flushes, drains, then pulses a CSR commit.
// Optional saturating commit counter enabled by defining EXCP_CTRL_STATS_EN.
module excp_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_excp_valid,
    input  logic [5:0]       if_ecode,
    input  logic [8:0]       if_subecode,
    input  logic [PC_W-1:0]  if_pc,
    input  logic             id_excp_valid,
    input  logic [5:0]       id_ecode,
    input  logic [8:0]       id_subecode,
    input  logic [PC_W-1:0]  id_pc,
    input  logic             exe_valid,
    input  logic             exe_excp_valid,
    input  logic [5:0]       exe_ecode,
    input  logic [8:0]       exe_subecode,
    input  logic [PC_W-1:0]  exe_pc,
    input  logic [PC_W-1:0]  exe_badv,
    input  logic             exe_etrn_req,
    input  logic             have_intrpt,
    input  logic             mem_busy,
    input  logic             csr_wen,
    output logic [81:0]      csr_bus,
    output logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] excp_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic            r_is_etrn;
    logic            r_in_excp;
    logic [5:0]      r_ecode;
    logic [8:0]      r_subecode;
    logic [PC_W-1:0] r_era;
    logic            r_use_badv;
    logic [PC_W-1:0] r_badv;

    logic            w_evt;
    logic            w_is_etrn;
    logic            w_in_excp;
    logic [5:0]      w_ecode;
    logic [8:0]      w_subecode;
    logic [PC_W-1:0] w_era;
    logic            w_use_badv;
    logic [PC_W-1:0] w_badv;

    // Fixed-priority event select; every event sets exactly one of in_excp/is_etrn.
    always_comb begin
        w_evt      = 1'b1;
        w_is_etrn  = 1'b0;
        w_in_excp  = 1'b0;
        w_ecode    = '0;
        w_subecode = '0;
        w_era      = '0;
        w_use_badv = 1'b0;
        w_badv     = '0;
        if (exe_valid && exe_excp_valid) begin
            w_in_excp  = 1'b1;
            w_ecode    = exe_ecode;
            w_subecode = exe_subecode;
            w_era      = exe_pc;
            w_use_badv = 1'b1;
            w_badv     = exe_badv;
        end else if (exe_valid && exe_etrn_req) begin
            w_is_etrn  = 1'b1;
        end else if (have_intrpt) begin
            w_in_excp  = 1'b1;
            w_era      = exe_valid ? exe_pc : id_pc;
        end else if (id_excp_valid) begin
            w_in_excp  = 1'b1;
            w_ecode    = id_ecode;
            w_subecode = id_subecode;
            w_era      = id_pc;
        end else if (if_excp_valid) begin
            w_in_excp  = 1'b1;
            w_ecode    = if_ecode;
            w_subecode = if_subecode;
            w_era      = if_pc;
            w_use_badv = 1'b1;
            w_badv     = if_pc;
        end else begin
            w_evt      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_evt) w_next = S_DRAIN;
            S_DRAIN:  if (!(mem_busy || csr_wen)) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Event is captured only in IDLE and stays frozen through DRAIN/COMMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_etrn  <= 1'b0;
            r_in_excp  <= 1'b0;
            r_ecode    <= '0;
            r_subecode <= '0;
            r_era      <= '0;
            r_use_badv <= 1'b0;
            r_badv     <= '0;
        end else if (r_state == S_IDLE && w_evt) begin
            r_is_etrn  <= w_is_etrn;
            r_in_excp  <= w_in_excp;
            r_ecode    <= w_ecode;
            r_subecode <= w_subecode;
            r_era      <= w_era;
            r_use_badv <= w_use_badv;
            r_badv     <= w_badv;
        end
    end

    always_comb begin
        flush   = (r_state != S_IDLE);
        busy    = (r_state != S_IDLE);
        csr_bus = '0;
        if (r_state == S_COMMIT)
            csr_bus = {r_is_etrn, r_in_excp, r_ecode, r_subecode, 32'(r_era),
                       r_use_badv, 32'(r_badv)};
    end

`ifdef EXCP_CTRL_STATS_EN
    logic [CNT_W-1:0] r_excp_count;

    // Saturating: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_excp_count <= '0;
        else if (r_state == S_COMMIT && r_in_excp && r_excp_count != {CNT_W{1'b1}})
            r_excp_count <= r_excp_count + CNT_W'(1);
    end

    assign excp_count = r_excp_count;
`else
    assign excp_count = '0;
`endif

endmodule

// File: doc/excp_ctrl.md
# excp_ctrl

Exception/ertn sequencer in front of the CSR file. Collects exception reports from IF, ID and EXE, the CSR interrupt-pending flag and EXE ertn requests. Selects one event by fixed priority, flushes the pipeline, and waits for outstanding memory traffic and CSR writes to drain. It then issues a single-cycle commit on the packed `csr_bus` consumed by the CSR file.

## Interface
Parameters:
- `PC_W`, 32, PC and bad-address width
- `CNT_W`, 16, width of the statistics counter (`EXCP_CTRL_STATS_EN` only)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low (asserted when 0)
- `if_excp_valid`  in  1  IF reports exception (ADEF)
- `if_ecode`/`if_subecode`  in  6/9  IF cause
- `if_pc`  in  PC_W  IF instruction PC (also used as BADV)
- `id_excp_valid`  in  1  ID reports exception (SYS/BRK/INE)
- `id_ecode`/`id_subecode`  in  6/9  ID cause
- `id_pc`  in  PC_W  ID PC
- `exe_valid`  in  1  EXE holds a live instruction
- `exe_excp_valid`  in  1  EXE reports exception (ALE)
- `exe_ecode`/`exe_subecode`  in  6/9  EXE cause
- `exe_pc`  in  PC_W  EXE PC
- `exe_badv`  in  PC_W  EXE faulting data address
- `exe_etrn_req`  in  1  EXE executing ertn
- `have_intrpt`  in  1  CSR interrupt pending and enabled
- `mem_busy`  in  1  data memory transaction outstanding
- `csr_wen`  in  1  CSR write in progress this cycle
- `csr_bus`  out  82  {is_etrn, in_excp, ecode[5:0], subecode[8:0], era[31:0], use_badv, bad_vaddr[31:0]}
- `flush`  out  1  kill IF/ID/EXE, hold fetch
- `busy`  out  1  state != IDLE
- `excp_count`  out  CNT_W  committed exception count

## Operation
- States: IDLE, DRAIN, COMMIT.
- IDLE: evaluates the inputs each cycle. On any event it latches the selected event into internal registers and goes to DRAIN.
- Priority, highest first:
  1. EXE exception (`exe_valid & exe_excp_valid`): era=exe_pc, use_badv=1, badv=exe_badv.
  2. EXE ertn (`exe_valid & exe_etrn_req`): is_etrn=1, in_excp=0.
  3. Interrupt (`have_intrpt`): ecode=0, subecode=0, era = exe_pc if exe_valid, else id_pc. use_badv=0.
  4. ID exception: era=id_pc, use_badv=0.
  5. IF exception: era=if_pc, use_badv=1, badv=if_pc.
- DRAIN: `flush`=1. Stays in DRAIN while `mem_busy | csr_wen`. Goes to COMMIT on the first cycle where both are 0.
- COMMIT: `flush`=1. Drives the latched `csr_bus` with in_excp or is_etrn high for exactly this one cycle. Next state is IDLE unconditionally.
- All event inputs are ignored in DRAIN and COMMIT. The latched event is frozen.
- `csr_bus` is all-zero in IDLE and DRAIN, so the CSR file sees no in_excp/is_etrn pulse outside COMMIT.
- Because `csr_wen` is 0 when entering COMMIT, the CSR file never sees an exception commit coinciding with a CSR write.
- A zero era or badv is valid data. No special-casing.

## Timing
- Reset (rst=0, asynchronous): state=IDLE. `csr_bus`=0, `flush`=0, `busy`=0, `excp_count`=0, latched event cleared. Reset asserted mid-DRAIN/COMMIT aborts the event with no commit pulse.
- Event sampled at edge N in IDLE: DRAIN from N+1, so `flush`/`busy` are high in cycle N+1.
- Minimum latency (mem_busy=csr_wen=0 at N+1): COMMIT in cycle N+2, IDLE in N+3. `flush` is high for 2 cycles.
- Each extra cycle of `mem_busy|csr_wen` in DRAIN delays COMMIT by one cycle. There is no timeout.
- A new event can be accepted in the first IDLE cycle after COMMIT (back-to-back, 3-cycle spacing).
- All outputs are registered or decoded from registered state only. No combinational input-to-output path.

## Configuration
- `EXCP_CTRL_STATS_EN` defined:
  - `excp_count` increments once per COMMIT with in_excp=1; ertn commits are not counted.
  - The counter saturates at 2^CNT_W−1 and does not wrap.
- Not defined: `excp_count` is tied to 0 and no counter flops exist.

## Test plan
- **Single IF ADEF, idle memory.** if_excp_valid=1, ecode=0x08, if_pc=0x1C000004 at cycle 0. Required: flush in cycles 1–2; COMMIT in cycle 2 with in_excp=1, era=0x1C000004, use_badv=1, bad_vaddr=0x1C000004; busy=0 in cycle 3.
- **Simultaneous events.** EXE ALE (exe_pc=0x100, exe_badv=0x203), ertn, interrupt and an ID SYS all in the same cycle. Required: commit with ecode=0x09, era=0x100, bad_vaddr=0x203, is_etrn=0. Exactly one commit pulse.
- **Interrupt with exe_valid=0.** have_intrpt=1, id_pc=0x2000. Required: in_excp=1, ecode=0, era=0x2000, use_badv=0.
- **Drain stretch.** ertn request with mem_busy high for 4 cycles, then csr_wen high for 1 more. Required: COMMIT at cycle 7 with is_etrn=1, in_excp=0; flush high in cycles 1–7; events during DRAIN ignored.
- **Reset mid-DRAIN.** rst=0 asynchronously while in DRAIN. Required: flush=0 and busy=0 immediately; no commit pulse after release; a fresh event afterward commits normally.
- **Stats (`EXCP_CTRL_STATS_EN`, CNT_W=2).** 5 exceptions plus 1 ertn. Required: excp_count reads 1, 2, 3, 3, 3; unchanged by the ertn. Without the macro: constant 0.
